// File: rtl/clock_panel_pkg.sv
// Shared types and constants for the front-panel clock controller:
// panel FSM states, halt status encodings and the rate-select wrap point.
package clock_panel_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALTED    = 2'd1,
    ST_STEP_FALL = 2'd2,
    ST_STEP_RISE = 2'd3
  } panel_state_t;

  localparam logic [1:0] HALT_RUN   = 2'b00;
  localparam logic [1:0] HALT_STEP  = 2'b01;
  localparam logic [1:0] HALT_PANEL = 2'b10;
  localparam logic [1:0] HALT_CPU   = 2'b11;

  localparam logic [1:0] FREQ_WRAP  = 2'b11;

  function automatic logic [1:0] halt_code(input panel_state_t s);
    logic [1:0] code;
    case (s)
      ST_RUN:       code = HALT_RUN;
      ST_HALTED:    code = HALT_PANEL;
      ST_STEP_FALL: code = HALT_STEP;
      ST_STEP_RISE: code = HALT_STEP;
      default:      code = HALT_RUN;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] next_freq(input logic [1:0] f);
    return (f == FREQ_WRAP) ? 2'b00 : f + 2'b01;
  endfunction

endpackage

// File: rtl/debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press (releases produce nothing).
module debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_prev;
  logic [CW-1:0] count;

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      count      <= '0;
    end else begin
      sync1      <= btn;
      sync2      <= sync1;
      level_prev <= level;
      if (sync2 != level) begin
        if (count == COUNT_LAST) begin
          level <= sync2;
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

  assign press = level & ~level_prev;

endmodule

// File: rtl/clock_panel.sv
// Front-panel controller for a divided CPU clock: rate select, run/halt,
// single-step over one divided-clock period, and a timed reset pulse.
module clock_panel
  import clock_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int RST_PULSE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_freq,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       btn_rst,
  input  logic       cpu_halt,
  input  logic       clk_out_fb,
  output logic [1:0] freq,
  output logic [1:0] halt,
  output logic       rst_out
);

  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

  logic freq_press;
  logic run_press;
  logic step_press;
  logic rst_press;

  logic [2:0]    fb_sync;
  logic          fb_rise;
  logic          fb_fall;
  logic [PW-1:0] pulse_cnt;

  panel_state_t state;
  panel_state_t state_next;
  logic [1:0]   halt_next;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_freq (
    .clk(clk), .reset(reset), .btn(btn_freq), .press(freq_press)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
    .clk(clk), .reset(reset), .btn(btn_run), .press(run_press)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
    .clk(clk), .reset(reset), .btn(btn_step), .press(step_press)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
    .clk(clk), .reset(reset), .btn(btn_rst), .press(rst_press)
  );

  // Two stages resynchronize the divider clock; the third is for edge detection.
  always_ff @(posedge clk) begin
    if (reset) fb_sync <= '0;
    else       fb_sync <= {fb_sync[1:0], clk_out_fb};
  end

  assign fb_rise = fb_sync[1] & ~fb_sync[2];
  assign fb_fall = ~fb_sync[1] & fb_sync[2];

  always_ff @(posedge clk) begin
    if (reset)           freq <= 2'b00;
    else if (freq_press) freq <= next_freq(freq);
  end

  // rst_out is a single flop so the divider and CPU see a glitch-free reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_cnt <= '0;
      rst_out   <= 1'b1;
    end else if (rst_press) begin
      pulse_cnt <= PULSE_LOAD;
      rst_out   <= 1'b1;
    end else begin
      rst_out <= (pulse_cnt > PULSE_ONE);
      if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      halt  <= HALT_RUN;
    end else begin
      state <= state_next;
      halt  <= halt_next;
    end
  end

  // Run always outranks step, and an active reset pulse parks the FSM in RUN.
  always_comb begin
    state_next = state;
    if (rst_out) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (run_press) state_next = ST_HALTED;
        end
        ST_HALTED: begin
          if (run_press)       state_next = ST_RUN;
          else if (step_press) state_next = ST_STEP_FALL;
        end
        ST_STEP_FALL: begin
          if (run_press)    state_next = ST_RUN;
          else if (fb_fall) state_next = ST_STEP_RISE;
        end
        ST_STEP_RISE: begin
          if (run_press)    state_next = ST_RUN;
          else if (fb_rise) state_next = ST_HALTED;
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    halt_next = cpu_halt ? HALT_CPU : halt_code(state_next);
  end

endmodule

// File: tb/tb_clock_panel.sv
// Randomized bench for clock_panel against an event-level model of the
// panel (run/halted/stepping, rate select, CPU halt overlay).
module tb_clock_panel;

  localparam int DEB    = 4;
  localparam int RSTW   = 16;
  localparam int SETTLE = DEB + 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_freq, btn_run, btn_step, btn_rst;
  logic       cpu_halt;
  logic       clk_out_fb;
  logic [1:0] freq;
  logic [1:0] halt;
  logic       rst_out;

  int checks   = 0;
  int failures = 0;

  typedef enum {M_RUN, M_HALTED, M_STEPPING} mstate_t;
  mstate_t m_state;
  int      m_freq;
  logic    m_cpu;

  clock_panel #(.DEBOUNCE_CYCLES(DEB), .RST_PULSE_CYCLES(RSTW)) dut (
    .clk(clk), .reset(reset),
    .btn_freq(btn_freq), .btn_run(btn_run), .btn_step(btn_step), .btn_rst(btn_rst),
    .cpu_halt(cpu_halt), .clk_out_fb(clk_out_fb),
    .freq(freq), .halt(halt), .rst_out(rst_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_halt();
    if (m_cpu) return 2'b11;
    case (m_state)
      M_RUN:    return 2'b00;
      M_HALTED: return 2'b10;
      default:  return 2'b01;
    endcase
  endfunction

  // Model of one clean press: bit0 freq, bit1 run, bit2 step.
  task automatic model_press(input logic [3:0] mask);
    if (mask[1]) begin
      m_state = (m_state == M_RUN) ? M_HALTED : M_RUN;
    end else if (mask[2] && m_state == M_HALTED) begin
      m_state = M_STEPPING;
    end
    if (mask[0]) m_freq = (m_freq + 1) % 4;
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int hold);
    btn_freq = mask[0];
    btn_run  = mask[1];
    btn_step = mask[2];
    btn_rst  = mask[3];
    repeat (hold) @(negedge clk);
    btn_freq = 1'b0;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    btn_rst  = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    applyStimulus(mask, SETTLE);
    model_press(mask);
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, ".halt"}, 32'(halt), 32'(exp_halt()));
    checkOutput({tag, ".freq"}, 32'(freq), 32'(m_freq));
    checkOutput({tag, ".rst_out"}, 32'(rst_out), 32'd0);
  endtask

  // Pulse must start 2 sync + DEB stable + 1 cycles after the press and last RSTW.
  task automatic rst_press_check();
    int first = -1;
    int cnt = 0;
    btn_rst = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == SETTLE + 1) btn_rst = 1'b0;
      @(negedge clk);
      if (rst_out) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    checkOutput("rst_width", 32'(cnt), 32'(RSTW));
    checkOutput("rst_start", 32'(first), 32'(DEB + 3));
    m_state = M_RUN;
  endtask

  task automatic fb_period();
    for (int p = 0; p < 4; p++) begin
      clk_out_fb = ~clk_out_fb;
      repeat (6) @(negedge clk);
    end
    if (m_state == M_STEPPING) m_state = M_HALTED;
  endtask

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1;
    btn_freq = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_rst = 1'b0;
    cpu_halt = 1'b0; clk_out_fb = 1'b0;
    m_state = M_RUN; m_freq = 0; m_cpu = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.rst_out", 32'(rst_out), 32'd1);
    checkOutput("reset.halt", 32'(halt), 32'd0);
    checkOutput("reset.freq", 32'(freq), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset.rst_fall", 32'(rst_out), 32'd0);

    for (int k = 0; k < 5; k++) begin
      press(4'b0001);
      checkOutput("freq_step", 32'(freq), 32'(m_freq));
    end
    checkOutput("freq_after5", 32'(freq), 32'd1);
    applyStimulus(4'b0001, 2);
    checkOutput("freq_glitch", 32'(freq), 32'd1);

    press(4'b0010);
    check_all("to_halted");
    press(4'b0100);
    check_all("step_enter");
    for (int t = 0; t < 24; t++) begin
      clk_out_fb = ((t / 8) % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      checkOutput("step_halt", 32'(halt), (t >= 18) ? 32'd2 : 32'd1);
    end
    m_state = M_HALTED;
    clk_out_fb = 1'b0;
    repeat (6) @(negedge clk);
    check_all("step_done");

    press(4'b0110);
    check_all("priority");

    cpu_halt = 1'b1; m_cpu = 1'b1;
    @(negedge clk);
    checkOutput("cpu_halt_on", 32'(halt), 32'd3);
    press(4'b0010);
    checkOutput("cpu_halt_hold", 32'(halt), 32'd3);
    cpu_halt = 1'b0; m_cpu = 1'b0;
    @(negedge clk);
    checkOutput("cpu_halt_off", 32'(halt), 32'd2);

    rst_press_check();
    check_all("rst_pulse");

    press(4'b0010);
    press(4'b0100);
    clk_out_fb = 1'b1; repeat (6) @(negedge clk);
    clk_out_fb = 1'b0; repeat (6) @(negedge clk);
    checkOutput("mid_step.halt", 32'(halt), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_reset.halt", 32'(halt), 32'd0);
    checkOutput("mid_reset.freq", 32'(freq), 32'd0);
    checkOutput("mid_reset.rst_out", 32'(rst_out), 32'd1);
    m_state = M_RUN; m_freq = 0;
    clk_out_fb = 1'b1; repeat (6) @(negedge clk);
    clk_out_fb = 1'b0; repeat (6) @(negedge clk);
    check_all("mid_reset.after");

    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 7);
      case (op)
        0: press(4'b0001);
        1: press(4'b0010);
        2: press(4'b0100);
        3: press(4'b0110);
        4: begin
          logic [3:0] gm;
          gm = 4'b0001 << $urandom_range(0, 3);
          applyStimulus(gm, $urandom_range(1, DEB - 1));
        end
        5: begin
          cpu_halt = ~cpu_halt; m_cpu = cpu_halt;
          @(negedge clk);
          checkOutput("rnd_cpu_halt", 32'(halt), 32'(exp_halt()));
        end
        6: fb_period();
        default: rst_press_check();
      endcase
      check_all("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_panel.md
CLOCK_PANEL -- requirements
Module: clock_panel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning stable-input cycles required before a button level is accepted.
REQ-002 SHALL have parameter RST_PULSE_CYCLES, default 16, meaning the width in clk cycles of a panel-generated reset pulse.
REQ-003 SHALL have port clk, input, 1 bit: board clock, the same clock that drives the clock divider.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports btn_freq, btn_run, btn_step and btn_rst, each input, 1 bit: raw asynchronous pushbuttons, active-high.
REQ-006 SHALL have port cpu_halt, input, 1 bit: level halt request from the processor.
REQ-007 SHALL have port clk_out_fb, input, 1 bit: divided clock fed back from the divider.
REQ-008 SHALL have port freq, output, 2 bits: divider rate select.
REQ-009 SHALL have port halt, output, 2 bits: 00 run, 01 stepping, 10 panel halt, 11 CPU halt.
REQ-010 SHALL have port rst_out, output, 1 bit: divider/CPU reset, active-high.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer and then a debouncer; the debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-012 A press event SHALL be a single-cycle pulse on the 0->1 transition of the debounced level; releases SHALL generate no event.
REQ-013 Each btn_freq press SHALL advance freq 00->01->10->11->00 (wrap-around).
REQ-014 Each btn_rst press SHALL assert rst_out for exactly RST_PULSE_CYCLES cycles, starting the cycle after the event; a press during an active pulse SHALL restart the count.
REQ-015 The panel FSM SHALL have the states RUN, HALTED, STEP_FALL and STEP_RISE.
REQ-016 RUN: a btn_run press SHALL go to HALTED; btn_step SHALL be ignored.
REQ-017 HALTED: a btn_run press SHALL go to RUN; a btn_step press SHALL go to STEP_FALL.
REQ-018 STEP_FALL SHALL wait for a synchronized falling edge of clk_out_fb and then go to STEP_RISE.
REQ-019 STEP_RISE SHALL wait for a synchronized rising edge of clk_out_fb and then go to HALTED, so that exactly one divided-clock period elapses per step.
REQ-020 In STEP_FALL or STEP_RISE, a btn_run press SHALL go to RUN (abort step); a btn_step press SHALL be ignored.
REQ-021 When btn_run and btn_step events occur in the same cycle, btn_run SHALL take priority.
REQ-022 halt SHALL be registered: 11 whenever cpu_halt=1, otherwise 00 in RUN, 10 in HALTED, and 01 in STEP_FALL or STEP_RISE.
REQ-023 cpu_halt SHALL NOT alter FSM state; removing cpu_halt SHALL restore the halt code of the current state on the next cycle.
REQ-024 While rst_out=1, the FSM SHALL be forced to RUN; freq SHALL be kept.
REQ-025 clk_out_fb SHALL be double-synchronized before edge detection.

Reset
REQ-026 On reset=1 at a clk edge: FSM=RUN, freq=00, halt=00, rst_out=1, all debouncer levels/counters=0, pulse counter=0.
REQ-027 rst_out SHALL follow reset combined with the pulse; it SHALL fall on the first cycle after reset deasserts when no pulse is active.
REQ-028 A reset applied during a step SHALL abandon the step without emitting any further halt code.

Structure
REQ-029 Package clock_panel_pkg SHALL hold the FSM state enum, the halt encodings (HALT_RUN, HALT_STEP, HALT_PANEL, HALT_CPU) and the freq wrap constant.
REQ-030 A sub-module debounce (synchronizer + counter + edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification
REQ-031 Freq: DEBOUNCE_CYCLES=4, five clean btn_freq presses -> freq 01,10,11,00,01; a 2-cycle glitch -> no change.
REQ-032 Step: HALTED, btn_step press, clk_out_fb toggling every 8 cycles -> halt=01 until the fb rise after the first fb fall, then halt=10; exactly one fb period elapses.
REQ-033 Priority: btn_run and btn_step pressed on the same cycle while HALTED -> RUN, halt=00.
REQ-034 CPU halt: cpu_halt=1 in RUN -> halt=11 next cycle; btn_run press meanwhile -> after cpu_halt=0, halt=10.
REQ-035 Reset pulse: btn_rst press with RST_PULSE_CYCLES=16 -> rst_out high for exactly 16 cycles, FSM=RUN, freq unchanged.
REQ-036 Mid-step reset: reset=1 in STEP_RISE -> next cycle FSM=RUN, halt=00, freq=00, rst_out=1.
